// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus data-memory port of the LSU.
//  slave  : the LSU's view (takes requests, returns responses, drives the memory).
//  master : the environment's view (execute stage + data memory).
//  reqValid/reqReady/reqWrite/reqAccess/reqUnsigned/reqAddr/reqData : request channel
//  rspValid/rspReady/rspData/rspErr                                 : response channel
//  memAccess/memRdEna/memRdAddr/memWrEna/memWrAddr/memWrData/memRdData : memory port
interface load_store_unit_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned MEM_ACCESS_WIDTH = 2;

  logic                        reqValid;
  logic                        reqReady;
  logic                        reqWrite;
  logic [MEM_ACCESS_WIDTH-1:0] reqAccess;
  logic                        reqUnsigned;
  logic [N-1:0]                reqAddr;
  logic [N-1:0]                reqData;

  logic                        rspValid;
  logic                        rspReady;
  logic [N-1:0]                rspData;
  logic                        rspErr;

  logic [MEM_ACCESS_WIDTH-1:0] memAccess;
  logic                        memRdEna;
  logic [N-1:0]                memRdAddr;
  logic                        memWrEna;
  logic [N-1:0]                memWrAddr;
  logic [N-1:0]                memWrData;
  logic [N-1:0]                memRdData;

  modport slave (
    input  reqValid, reqWrite, reqAccess, reqUnsigned, reqAddr, reqData,
    output reqReady,
    output rspValid, rspData, rspErr,
    input  rspReady,
    output memAccess, memRdEna, memRdAddr, memWrEna, memWrAddr, memWrData,
    input  memRdData
  );

  modport master (
    output reqValid, reqWrite, reqAccess, reqUnsigned, reqAddr, reqData,
    input  reqReady,
    input  rspValid, rspData, rspErr,
    output rspReady,
    input  memAccess, memRdEna, memRdAddr, memWrEna, memWrAddr, memWrData,
    output memRdData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a byte-addressed,
// little-endian data memory with a 1-cycle registered read.
//  clk  : rising-edge clock
//  rstN : asynchronous active-low reset
//  bus  : load_store_unit_if.slave (request, response and memory port)
// Access encoding: 0 = BYTE, 1 = HALF, anything else = WORD.
module load_store_unit #(
  parameter int unsigned N      = 32,
  parameter int unsigned LENGTH = 512
) (
  input  logic              clk,
  input  logic              rstN,
  load_store_unit_if.slave  bus
);

  localparam int unsigned MEM_ACCESS_WIDTH = 2;
  localparam logic [MEM_ACCESS_WIDTH-1:0] ACC_BYTE = 2'd0;
  localparam logic [MEM_ACCESS_WIDTH-1:0] ACC_HALF = 2'd1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  // One past the last valid byte address, widened so addr+size-1 cannot wrap.
  localparam logic [N:0] ADDR_LIMIT = (N+1)'(LENGTH * 4);

  logic [1:0]                  state_q, state_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [N-1:0]                rsp_data_q, rsp_data_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [MEM_ACCESS_WIDTH-1:0] access_q, access_d;
  logic                        unsigned_q, unsigned_d;

  logic         accept_c;
  logic [2:0]   size_c;
  logic [N:0]   last_byte_c;
  logic         misaligned_c;
  logic         req_err_c;
  logic [N-1:0] rd_fmt_c;
  logic         mem_rd_ena_c;
  logic         mem_wr_ena_c;

  // Request decode: byte count, alignment and range of the presented request.
  assign accept_c = bus.reqValid && (state_q == ST_IDLE);

  always_comb begin
    size_c = 3'd4;
    if (bus.reqAccess == ACC_BYTE)      size_c = 3'd1;
    else if (bus.reqAccess == ACC_HALF) size_c = 3'd2;
  end

  assign last_byte_c  = {1'b0, bus.reqAddr} + (N+1)'(size_c - 3'd1);
  assign misaligned_c = ((size_c == 3'd2) && bus.reqAddr[0]) ||
                        ((size_c == 3'd4) && (bus.reqAddr[1:0] != 2'b00));
  assign req_err_c    = misaligned_c || (last_byte_c >= ADDR_LIMIT);

  // Load data alignment: memory returns the addressed byte in bits [7:0].
  always_comb begin
    rd_fmt_c = bus.memRdData;
    case (access_q)
      ACC_BYTE: rd_fmt_c = {{(N-8){~unsigned_q & bus.memRdData[7]}}, bus.memRdData[7:0]};
      ACC_HALF: rd_fmt_c = {{(N-16){~unsigned_q & bus.memRdData[15]}}, bus.memRdData[15:0]};
      default:  rd_fmt_c = bus.memRdData;
    endcase
  end

  // Next-state and memory strobe decode.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    access_d     = access_q;
    unsigned_d   = unsigned_q;
    mem_rd_ena_c = 1'b0;
    mem_wr_ena_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          access_d   = bus.reqAccess;
          unsigned_d = bus.reqUnsigned;
          if (req_err_c) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else if (bus.reqWrite) begin
            mem_wr_ena_c = 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = '0;
            rsp_err_d    = 1'b0;
            state_d      = ST_RESP;
          end else begin
            mem_rd_ena_c = 1'b1;
            state_d      = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rd_fmt_c;
        rsp_err_d   = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      access_q    <= ACC_BYTE;
      unsigned_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      access_q    <= access_d;
      unsigned_q  <= unsigned_d;
    end
  end

  assign bus.reqReady  = (state_q == ST_IDLE);
  assign bus.rspValid  = rsp_valid_q;
  assign bus.rspData   = rsp_data_q;
  assign bus.rspErr    = rsp_err_q;

  // Address/data/access follow the request; only the enables are gated.
  assign bus.memAccess = bus.reqAccess;
  assign bus.memRdEna  = mem_rd_ena_c;
  assign bus.memRdAddr = bus.reqAddr;
  assign bus.memWrEna  = mem_wr_ena_c;
  assign bus.memWrAddr = bus.reqAddr;
  assign bus.memWrData = bus.reqData;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives load_store_unit through its interface, models the data
// memory, and checks every response against a byte-array reference model.
module tb_load_store_unit;

  localparam int unsigned N         = 32;
  localparam int unsigned LENGTH    = 512;
  localparam int unsigned MEM_BYTES = LENGTH * 4;
  localparam logic [1:0]  A_B = 2'd0;
  localparam logic [1:0]  A_H = 2'd1;
  localparam logic [1:0]  A_W = 2'd2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.N(N)) bus();

  load_store_unit #(.N(N), .LENGTH(LENGTH)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tb_mem  [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic int acc_size(input logic [1:0] acc);
    if (acc == A_B) return 1;
    if (acc == A_H) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] mem_byte(input longint a);
    if (a >= 0 && a < longint'(MEM_BYTES)) return tb_mem[int'(a)];
    return 8'h00;
  endfunction

  // Data memory: byte writes at the strobe edge, registered read of 4 bytes from rdAddr.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) tb_mem[i] <= 8'h00;
    end else begin
      if (bus.memWrEna) begin
        for (int i = 0; i < acc_size(bus.memAccess); i++)
          if (longint'(bus.memWrAddr) + i < longint'(MEM_BYTES))
            tb_mem[int'(bus.memWrAddr) + i] <= bus.memWrData[8*i +: 8];
      end
      if (bus.memRdEna) begin
        bus.memRdData <= {mem_byte(longint'(bus.memRdAddr) + 3), mem_byte(longint'(bus.memRdAddr) + 2),
                          mem_byte(longint'(bus.memRdAddr) + 1), mem_byte(longint'(bus.memRdAddr))};
      end
    end
  end

  // Reference: error rule straight from size/alignment/range arithmetic.
  function automatic bit model_err(input logic [1:0] acc, input logic [31:0] addr);
    int sz;
    sz = acc_size(acc);
    if (sz == 2 && (addr % 2) != 0) return 1'b1;
    if (sz == 4 && (addr % 4) != 0) return 1'b1;
    return (longint'(addr) + sz - 1) >= longint'(MEM_BYTES);
  endfunction

  // Reference: little-endian gather of sz bytes, then numeric sign/zero extension.
  function automatic logic [31:0] model_load(input logic [1:0] acc, input bit uns, input logic [31:0] addr);
    longint v;
    int sz;
    sz = acc_size(acc);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!uns && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] acc, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    for (int i = 0; i < acc_size(acc); i++) begin
      ref_mem[int'(addr) + i] = d[7:0];
      d = d >> 8;
    end
  endtask

  // One complete transaction; hold = cycles rspReady stays low after rspValid.
  task automatic do_txn(input bit wr, input logic [1:0] acc, input bit uns,
                        input logic [31:0] addr, input logic [31:0] data, input int hold);
    bit          err;
    logic [31:0] exp_d;
    int          exp_lat;
    int          lat;
    err     = model_err(acc, addr);
    exp_lat = (wr || err) ? 1 : 2;
    exp_d   = (wr || err) ? 32'h0 : model_load(acc, uns, addr);

    @(negedge clk);
    vectors++;
    if (bus.reqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle addr=%h got=%b exp=1", addr, bus.reqReady);
    end
    bus.reqValid    = 1'b1;
    bus.reqWrite    = wr;
    bus.reqAccess   = acc;
    bus.reqUnsigned = uns;
    bus.reqAddr     = addr;
    bus.reqData     = data;
    #1;
    vectors++;
    if (bus.memWrEna !== (wr && !err) || bus.memRdEna !== (!wr && !err)) begin
      miscompares++;
      $display("FAIL strobes addr=%h wr=%0d err=%0d got rd=%b wr=%b exp rd=%b wr=%b",
               addr, wr, err, bus.memRdEna, bus.memWrEna, !wr && !err, wr && !err);
    end
    if (wr && !err) begin
      vectors++;
      if (bus.memWrAddr !== addr || bus.memWrData !== data || bus.memAccess !== acc) begin
        miscompares++;
        $display("FAIL wr_port got addr=%h data=%h acc=%0d exp addr=%h data=%h acc=%0d",
                 bus.memWrAddr, bus.memWrData, bus.memAccess, addr, data, acc);
      end
    end
    if (!wr && !err) begin
      vectors++;
      if (bus.memRdAddr !== addr) begin
        miscompares++;
        $display("FAIL rd_addr got=%h exp=%h", bus.memRdAddr, addr);
      end
    end

    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    if (wr && !err) model_store(acc, addr, data);

    lat = 1;
    while (bus.rspValid !== 1'b1 && lat < 8) begin
      vectors++;
      if (bus.reqReady !== 1'b0 || bus.memRdEna !== 1'b0 || bus.memWrEna !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_quiet got ready=%b rd=%b wr=%b exp all 0",
                 bus.reqReady, bus.memRdEna, bus.memWrEna);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL rsp_latency addr=%h got=%0d exp=%0d", addr, lat, exp_lat);
    end
    vectors++;
    if (bus.rspData !== exp_d || bus.rspErr !== err) begin
      miscompares++;
      $display("FAIL rsp_payload wr=%0d acc=%0d uns=%0d addr=%h got data=%h err=%b exp data=%h err=%b",
               wr, acc, uns, addr, bus.rspData, bus.rspErr, exp_d, err);
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.rspValid !== 1'b1 || bus.rspData !== exp_d || bus.rspErr !== err || bus.reqReady !== 1'b0) begin
        miscompares++;
        $display("FAIL rsp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=%b rdy=0",
                 h, bus.rspValid, bus.rspData, bus.rspErr, bus.reqReady, exp_d, err);
      end
    end

    @(negedge clk);
    bus.rspReady = 1'b1;
    @(posedge clk);
    #1;
    bus.rspReady = 1'b0;
    vectors++;
    if (bus.rspValid !== 1'b0 || bus.reqReady !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_release got v=%b rdy=%b exp v=0 rdy=1", bus.rspValid, bus.reqReady);
    end
  endtask

  task automatic test_reset();
    bus.reqValid    = 1'b0;
    bus.reqWrite    = 1'b0;
    bus.reqAccess   = A_W;
    bus.reqUnsigned = 1'b0;
    bus.reqAddr     = '0;
    bus.reqData     = '0;
    bus.rspReady    = 1'b0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
    rstN      = 1'b0;
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.rspValid !== 1'b0 || bus.rspData !== 32'h0 || bus.rspErr !== 1'b0 ||
        bus.reqReady !== 1'b1 || bus.memRdEna !== 1'b0 || bus.memWrEna !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b d=%h e=%b rdy=%b rd=%b wr=%b exp v=0 d=0 e=0 rdy=1 rd=0 wr=0",
               bus.rspValid, bus.rspData, bus.rspErr, bus.reqReady, bus.memRdEna, bus.memWrEna);
    end
    @(negedge clk);
    mem_clear = 1'b0;
    rstN      = 1'b1;
  endtask

  task automatic test_directed();
    do_txn(1'b1, A_W, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h10, 32'h0, 0);
    do_txn(1'b0, A_B, 1'b0, 32'h10, 32'h0, 0);
    do_txn(1'b0, A_B, 1'b1, 32'h10, 32'h0, 0);
    do_txn(1'b0, A_H, 1'b0, 32'h12, 32'h0, 0);
    do_txn(1'b0, A_H, 1'b1, 32'h12, 32'h0, 0);
    do_txn(1'b1, A_B, 1'b0, 32'h11, 32'h12345678, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_errors();
    do_txn(1'b1, A_W, 1'b0, 32'h7FC, 32'hA5C3_9E81, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h02, 32'h0, 0);
    do_txn(1'b1, A_H, 1'b0, 32'h7FF, 32'hFFFF_FFFF, 0);
    do_txn(1'b1, A_B, 1'b0, 32'h800, 32'h0000_0011, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h800, 32'h0, 0);
    do_txn(1'b0, A_H, 1'b0, 32'h7FE, 32'h0, 0);
    do_txn(1'b0, A_B, 1'b1, 32'h7FF, 32'h0, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h7FC, 32'h0, 0);
    do_txn(1'b0, A_W, 1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, A_W, 1'b0, 32'h10, 32'h0, 3);
    do_txn(1'b1, A_H, 1'b0, 32'h20, 32'h0000_8001, 2);
    do_txn(1'b0, A_H, 1'b0, 32'h20, 32'h0, 1);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = 1'b0;
    bus.reqAccess = A_W;
    bus.reqAddr   = 32'h10;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    rstN = 1'b0;
    #1;
    vectors++;
    if (bus.rspValid !== 1'b0 || bus.reqReady !== 1'b1 || bus.memRdEna !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_load got v=%b rdy=%b rd=%b exp v=0 rdy=1 rd=0",
               bus.rspValid, bus.reqReady, bus.memRdEna);
    end
    @(negedge clk);
    rstN = 1'b1;
    do_txn(1'b0, A_W, 1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          r;
      logic [31:0] addr;
      r = int'($urandom_range(0, 9));
      if (r < 7)      addr = 32'($urandom_range(0, 63));
      else if (r < 9) addr = 32'(MEM_BYTES - 8 + $urandom_range(0, 15));
      else            addr = $urandom;
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             addr, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
